qed_mode_ctrl: RTL and testbench
================================

# qed_mode_ctrl

Parametrised QED mode controller, successor to the single-round QED state machine. It sequences the core through five modes: original execution, drain, duplicate execution, drain, check. It also adds:
- instruction-count-bounded segments;
- drain watchdogs;
- an original-vs-duplicate instruction-count check;
- a sticky error/halt state.

It sits beside the fetch/issue logic. It drives the mode bus used by the instruction duplicator and result comparator.

## Interface
- MAX_SEG, default 64: max instructions per original segment before a forced segment end; legal range 1..65535.
- DRAIN_TIMEOUT, default 255: max consecutive wait-mode cycles with the pipeline non-empty before a timeout error; legal range ≥1.
- CNT_W, default 16: width of the completed-check counter.
- SEG_W (derived, not overridable): $clog2(MAX_SEG+1).
- Timer width (derived, not overridable): $clog2(DRAIN_TIMEOUT+1).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- qed_en  in  1  enables QED rounds; sampled only in ORIGINAL.
- insn_valid  in  1  one instruction issued this cycle.
- is_branch  in  1  the issued instruction is a branch; meaningful only with insn_valid.
- pipeline_empty  in  1  pipeline fully drained.
- mode  out  3  current mode: ORIGINAL=0, WAIT1=1, DUP=2, WAIT2=3, CHECK=4, HALT=5.
- mode_change  out  1  high for the first cycle of every new mode.
- seg_len  out  SEG_W  instructions counted in the current/last original segment.
- err_timeout  out  1  sticky: drain watchdog expired.
- err_count  out  1  sticky: duplicate count differed from original count.
- checks_done  out  CNT_W  saturating count of passed checks.

## Operation
- All outputs are registered.
- Asynchronous reset forces: mode=ORIGINAL, mode_change=0, seg_len=0, dup_cnt=0, timer=0, err_timeout=0, err_count=0, checks_done=0.
- ORIGINAL:
  - qed_en=0: hold ORIGINAL; seg_len is held at 0.
  - qed_en=1: each insn_valid increments seg_len.
  - Exit to WAIT1 when insn_valid && (is_branch || seg_len+1==MAX_SEG). The exiting instruction is counted.
- WAIT1: the timer counts cycles.
  - pipeline_empty → DUP.
  - Else, if timer==DRAIN_TIMEOUT-1 → HALT and set err_timeout.
  - The timer clears on every mode change.
- DUP:
  - Each insn_valid increments dup_cnt.
  - Exit to WAIT2 when insn_valid && (is_branch || dup_cnt+1==seg_len). The exiting instruction is counted.
- WAIT2: identical to WAIT1, but pipeline_empty → CHECK.
- CHECK (one cycle):
  - dup_cnt==seg_len: checks_done increments (saturates at all-ones) and mode → ORIGINAL.
  - Otherwise: set err_count and mode → HALT.
  - On leaving CHECK, seg_len and dup_cnt clear.
- HALT: absorbing. The only exit is rst_n.
- qed_en falling outside ORIGINAL has no effect; the round completes.
- is_branch with insn_valid=0 is ignored. pipeline_empty is ignored outside WAIT1/WAIT2.
- Counters never wrap. seg_len ≤ MAX_SEG and dup_cnt ≤ seg_len by construction.

## Timing
- Next mode is computed from same-cycle inputs. The new mode is visible on `mode` the following cycle, with mode_change=1 in that cycle.
- Minimum round is 5 cycles: 1 ORIGINAL cycle (branch), 1 WAIT1 (already empty), 1 DUP (branch at dup_cnt+1==seg_len=1), 1 WAIT2, 1 CHECK.
- pipeline_empty in the first wait cycle means exactly 1 cycle in that wait mode.
- Timeout: DRAIN_TIMEOUT consecutive wait cycles with pipeline_empty=0 → HALT on the next edge.
  - pipeline_empty=1 on cycle DRAIN_TIMEOUT wins: normal transition, no error.
- Error flags assert in the same cycle mode becomes HALT.
- rst_n assertion mid-round returns to reset values immediately, without waiting for clk. Deassertion is synchronised externally.

## Test plan
- Basic round:
  - Stimulus: qed_en=1, insn_valid 3 cycles with is_branch on the 3rd; pipeline_empty after 2 WAIT1 cycles; 3 DUP insns with the branch on the 3rd; empty immediately in WAIT2.
  - Required: mode 0→1→2→3→4→0, seg_len=3, checks_done=1, mode_change pulsed 5 times.
- Forced segment end:
  - Stimulus: MAX_SEG=4, 4 non-branch instructions.
  - Required: WAIT1 after the 4th, seg_len=4; DUP exits after its 4th instruction.
- Count mismatch:
  - Stimulus: seg_len=5, branch on the 2nd DUP instruction.
  - Required: WAIT2 then CHECK, then mode=5, err_count=1, checks_done unchanged; further inputs ignored.
- Drain watchdog:
  - Stimulus: DRAIN_TIMEOUT=8, pipeline_empty held 0 in WAIT2.
  - Required: mode=5, err_timeout=1 exactly 8 cycles after WAIT2 entry.
  - Repeat with empty=1 on the 8th cycle → CHECK, no error.
- Enable and reset:
  - qed_en=0 with branches → mode stays 0, seg_len=0.
  - Async rst_n low mid-DUP → all outputs return to reset values before the next clk edge.
- Saturation:
  - Stimulus: CNT_W=2, 5 passing rounds.
  - Required: checks_done=3.

Source files
------------

// File: rtl/qed_mode_ctrl.sv
// qed_mode_ctrl: QED round sequencer.
// Steps the core through ORIGINAL -> WAIT1 -> DUP -> WAIT2 -> CHECK -> ORIGINAL.
// Original segments end on a branch or after MAX_SEG instructions. Each drain
// (wait) mode has a watchdog. The duplicate instruction count is checked against
// the original count. Any error parks the block in HALT until reset.
//
// Ports:
//   clk            in   clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   qed_en         in   enable QED rounds (sampled only in ORIGINAL)
//   insn_valid     in   one instruction issued this cycle
//   is_branch      in   issued instruction is a branch (qualified by insn_valid)
//   pipeline_empty in   pipeline fully drained (used only in WAIT1/WAIT2)
//   mode           out  ORIGINAL=0 WAIT1=1 DUP=2 WAIT2=3 CHECK=4 HALT=5
//   mode_change    out  first cycle of a new mode
//   seg_len        out  instructions in the current/last original segment
//   err_timeout    out  sticky drain watchdog error
//   err_count      out  sticky duplicate-count mismatch error
//   checks_done    out  saturating count of passed checks
module qed_mode_ctrl #(
   parameter int unsigned MAX_SEG       = 64,
   parameter int unsigned DRAIN_TIMEOUT = 255,
   parameter int unsigned CNT_W         = 16
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             qed_en,
   input  logic                             insn_valid,
   input  logic                             is_branch,
   input  logic                             pipeline_empty,
   output logic [2:0]                       mode,
   output logic                             mode_change,
   output logic [$clog2(MAX_SEG+1)-1:0]     seg_len,
   output logic                             err_timeout,
   output logic                             err_count,
   output logic [CNT_W-1:0]                 checks_done
);

   localparam int unsigned SEG_W = $clog2(MAX_SEG + 1);
   localparam int unsigned TMR_W = $clog2(DRAIN_TIMEOUT + 1);

   typedef enum logic [2:0] {
      StOrig  = 3'd0,
      StWait1 = 3'd1,
      StDup   = 3'd2,
      StWait2 = 3'd3,
      StCheck = 3'd4,
      StHalt  = 3'd5
   } state_e;

   state_e               state_q, state_d;
   logic                 mode_change_q, mode_change_d;
   logic [SEG_W-1:0]     seg_q, seg_d;
   logic [SEG_W-1:0]     dup_q, dup_d;
   logic [TMR_W-1:0]     timer_q, timer_d;
   logic                 err_timeout_q, err_timeout_d;
   logic                 err_count_q, err_count_d;
   logic [CNT_W-1:0]     checks_q, checks_d;

   logic [SEG_W-1:0]     seg_inc, dup_inc;
   logic                 timer_last;
   logic                 in_wait;

   assign seg_inc    = seg_q + SEG_W'(1);
   assign dup_inc    = dup_q + SEG_W'(1);
   assign timer_last = (timer_q == TMR_W'(DRAIN_TIMEOUT - 1));
   assign in_wait    = (state_q == StWait1) || (state_q == StWait2);

   always_comb begin
      state_d       = state_q;
      seg_d         = seg_q;
      dup_d         = dup_q;
      err_timeout_d = err_timeout_q;
      err_count_d   = err_count_q;
      checks_d      = checks_q;

      unique case (state_q)
         StOrig: begin
            if (!qed_en) begin
               seg_d = '0;
            end else if (insn_valid) begin
               seg_d = seg_inc;
               if (is_branch || (seg_inc == SEG_W'(MAX_SEG))) begin
                  state_d = StWait1;
               end
            end
         end
         StWait1, StWait2: begin
            // A drained pipeline beats the watchdog on the same cycle.
            if (pipeline_empty) begin
               state_d = (state_q == StWait1) ? StDup : StCheck;
            end else if (timer_last) begin
               state_d       = StHalt;
               err_timeout_d = 1'b1;
            end
         end
         StDup: begin
            if (insn_valid) begin
               dup_d = dup_inc;
               if (is_branch || (dup_inc == seg_q)) begin
                  state_d = StWait2;
               end
            end
         end
         StCheck: begin
            if (dup_q == seg_q) begin
               if (checks_q != '1) begin
                  checks_d = checks_q + CNT_W'(1);
               end
               state_d = StOrig;
            end else begin
               err_count_d = 1'b1;
               state_d     = StHalt;
            end
            seg_d = '0;
            dup_d = '0;
         end
         StHalt: begin
         end
         default: begin
            state_d = StHalt;
         end
      endcase

      mode_change_d = (state_d != state_q);

      // Timer counts consecutive cycles inside one wait mode only.
      if (state_d != state_q) begin
         timer_d = '0;
      end else if (in_wait) begin
         timer_d = timer_q + TMR_W'(1);
      end else begin
         timer_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= StOrig;
         mode_change_q <= 1'b0;
         seg_q         <= '0;
         dup_q         <= '0;
         timer_q       <= '0;
         err_timeout_q <= 1'b0;
         err_count_q   <= 1'b0;
         checks_q      <= '0;
      end else begin
         state_q       <= state_d;
         mode_change_q <= mode_change_d;
         seg_q         <= seg_d;
         dup_q         <= dup_d;
         timer_q       <= timer_d;
         err_timeout_q <= err_timeout_d;
         err_count_q   <= err_count_d;
         checks_q      <= checks_d;
      end
   end

   assign mode        = state_q;
   assign mode_change = mode_change_q;
   assign seg_len     = seg_q;
   assign err_timeout = err_timeout_q;
   assign err_count   = err_count_q;
   assign checks_done = checks_q;

endmodule

// File: tb/tb_qed_mode_ctrl.sv
module tb_qed_mode_ctrl;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic qed_en = 1'b0;
   logic insn_valid = 1'b0;
   logic is_branch = 1'b0;
   logic pipeline_empty = 1'b0;

   // DUT a: long segments, short watchdog, 2-bit check counter.
   logic [2:0] a_mode;
   logic       a_mc;
   logic [6:0] a_seg;
   logic       a_errt, a_errc;
   logic [1:0] a_chk;

   // DUT b: MAX_SEG=4 for forced segment ends; shares stimulus with a.
   logic [2:0] b_mode;
   logic       b_mc;
   logic [2:0] b_seg;
   logic       b_errt, b_errc;
   logic [1:0] b_chk;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   qed_mode_ctrl #(.MAX_SEG(64), .DRAIN_TIMEOUT(8), .CNT_W(2)) dut_a (
      .clk(clk), .rst_n(rst_n), .qed_en(qed_en), .insn_valid(insn_valid),
      .is_branch(is_branch), .pipeline_empty(pipeline_empty), .mode(a_mode),
      .mode_change(a_mc), .seg_len(a_seg), .err_timeout(a_errt), .err_count(a_errc),
      .checks_done(a_chk)
   );

   qed_mode_ctrl #(.MAX_SEG(4), .DRAIN_TIMEOUT(8), .CNT_W(2)) dut_b (
      .clk(clk), .rst_n(rst_n), .qed_en(qed_en), .insn_valid(insn_valid),
      .is_branch(is_branch), .pipeline_empty(pipeline_empty), .mode(b_mode),
      .mode_change(b_mc), .seg_len(b_seg), .err_timeout(b_errt), .err_count(b_errc),
      .checks_done(b_chk)
   );

   typedef struct {
      logic       en, v, b, e;
      logic [2:0] mode;
      logic       mc;
      logic [6:0] seg;
      logic [1:0] chk;
   } vec_t;

   vec_t tbl[14];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic step(input logic en, input logic v, input logic b, input logic e);
      qed_en = en;
      insn_valid = v;
      is_branch = b;
      pipeline_empty = e;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      qed_en = 1'b0;
      insn_valid = 1'b0;
      is_branch = 1'b0;
      pipeline_empty = 1'b0;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   function automatic vec_t mk(input logic en, v, b, e, input logic [2:0] m, input logic mc,
                               input logic [6:0] s, input logic [1:0] c);
      vec_t r;
      r.en = en; r.v = v; r.b = b; r.e = e;
      r.mode = m; r.mc = mc; r.seg = s; r.chk = c;
      return r;
   endfunction

   initial begin : watchdog
      #200000;
      $display("FAIL global_timeout: got running, expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      int mc_cnt;
      // Basic round, then enable/ignore cases. Rows: inputs -> outputs after the edge.
      tbl[0]  = mk(1, 1, 0, 0, 3'd0, 0, 7'd1, 2'd0);
      tbl[1]  = mk(1, 1, 0, 1, 3'd0, 0, 7'd2, 2'd0); // empty ignored in ORIGINAL
      tbl[2]  = mk(1, 1, 1, 0, 3'd1, 1, 7'd3, 2'd0);
      tbl[3]  = mk(1, 0, 0, 0, 3'd1, 0, 7'd3, 2'd0);
      tbl[4]  = mk(1, 0, 0, 1, 3'd2, 1, 7'd3, 2'd0);
      tbl[5]  = mk(1, 1, 0, 0, 3'd2, 0, 7'd3, 2'd0);
      tbl[6]  = mk(0, 1, 0, 0, 3'd2, 0, 7'd3, 2'd0); // qed_en drop ignored in DUP
      tbl[7]  = mk(1, 1, 1, 0, 3'd3, 1, 7'd3, 2'd0);
      tbl[8]  = mk(1, 0, 0, 1, 3'd4, 1, 7'd3, 2'd0);
      tbl[9]  = mk(1, 0, 0, 0, 3'd0, 1, 7'd0, 2'd1);
      tbl[10] = mk(1, 0, 1, 0, 3'd0, 0, 7'd0, 2'd1); // branch without valid
      tbl[11] = mk(0, 1, 1, 0, 3'd0, 0, 7'd0, 2'd1);
      tbl[12] = mk(0, 1, 1, 1, 3'd0, 0, 7'd0, 2'd1);
      tbl[13] = mk(0, 1, 0, 0, 3'd0, 0, 7'd0, 2'd1);

      do_reset();
      check("reset mode", 32'(a_mode), 0);
      check("reset mode_change", 32'(a_mc), 0);
      check("reset seg_len", 32'(a_seg), 0);
      check("reset err_timeout", 32'(a_errt), 0);
      check("reset err_count", 32'(a_errc), 0);
      check("reset checks_done", 32'(a_chk), 0);

      mc_cnt = 0;
      for (int i = 0; i < 14; i++) begin
         step(tbl[i].en, tbl[i].v, tbl[i].b, tbl[i].e);
         check($sformatf("row%0d mode", i), 32'(a_mode), 32'(tbl[i].mode));
         check($sformatf("row%0d mode_change", i), 32'(a_mc), 32'(tbl[i].mc));
         check($sformatf("row%0d seg_len", i), 32'(a_seg), 32'(tbl[i].seg));
         check($sformatf("row%0d checks_done", i), 32'(a_chk), 32'(tbl[i].chk));
         check($sformatf("row%0d errors", i), 32'({a_errt, a_errc}), 0);
         if (i < 10 && a_mc === 1'b1) mc_cnt++;
      end
      check("basic mode_change pulses", 32'(mc_cnt), 5);

      // Forced segment end on dut b (MAX_SEG=4).
      do_reset();
      for (int k = 1; k <= 4; k++) begin
         step(1, 1, 0, 1);
         check($sformatf("force seg ins%0d mode", k), 32'(b_mode), (k == 4) ? 1 : 0);
         check($sformatf("force seg ins%0d seg_len", k), 32'(b_seg), 32'(k));
      end
      step(1, 0, 0, 1);
      check("force dup entry", 32'(b_mode), 2);
      for (int k = 1; k <= 4; k++) begin
         step(1, 1, 0, 0);
         check($sformatf("force dup ins%0d mode", k), 32'(b_mode), (k == 4) ? 3 : 2);
      end
      step(1, 0, 0, 1);
      step(1, 0, 0, 0);
      check("force round mode", 32'(b_mode), 0);
      check("force round checks_done", 32'(b_chk), 1);

      // Count mismatch: seg_len=5, branch on 2nd DUP instruction.
      do_reset();
      for (int k = 0; k < 4; k++) step(1, 1, 0, 0);
      step(1, 1, 1, 0);
      check("mis seg_len", 32'(a_seg), 5);
      check("mis wait1", 32'(a_mode), 1);
      step(1, 0, 0, 1);
      step(1, 1, 0, 0);
      step(1, 1, 1, 0);
      check("mis wait2", 32'(a_mode), 3);
      step(1, 0, 0, 1);
      check("mis check", 32'(a_mode), 4);
      step(1, 0, 0, 0);
      check("mis halt mode", 32'(a_mode), 5);
      check("mis halt mode_change", 32'(a_mc), 1);
      check("mis err_count", 32'(a_errc), 1);
      check("mis err_timeout", 32'(a_errt), 0);
      check("mis checks_done", 32'(a_chk), 0);
      for (int k = 0; k < 4; k++) step(1, 1, 1, 1);
      check("mis halt sticky mode", 32'(a_mode), 5);
      check("mis halt sticky mc", 32'(a_mc), 0);
      check("mis halt sticky err", 32'(a_errc), 1);

      // Drain watchdog in WAIT2 (DRAIN_TIMEOUT=8).
      for (int rep = 0; rep < 2; rep++) begin
         do_reset();
         step(1, 1, 1, 0);
         step(1, 0, 0, 1);
         step(1, 1, 1, 0);
         check($sformatf("wd%0d wait2 entry", rep), 32'(a_mode), 3);
         for (int k = 1; k <= 8; k++) begin
            step(1, 0, 0, (rep == 1 && k == 8) ? 1'b1 : 1'b0);
            if (k < 8) begin
               check($sformatf("wd%0d cycle%0d mode", rep, k), 32'(a_mode), 3);
            end
         end
         check($sformatf("wd%0d final mode", rep), 32'(a_mode), (rep == 0) ? 5 : 4);
         check($sformatf("wd%0d err_timeout", rep), 32'(a_errt), (rep == 0) ? 1 : 0);
         check($sformatf("wd%0d err_count", rep), 32'(a_errc), 0);
      end

      // Async reset mid-DUP.
      do_reset();
      step(1, 1, 0, 0);
      step(1, 1, 0, 0);
      step(1, 1, 1, 0);
      step(1, 0, 0, 1);
      step(1, 1, 0, 0);
      check("arst pre mode", 32'(a_mode), 2);
      check("arst pre seg_len", 32'(a_seg), 3);
      #1 rst_n = 1'b0;
      #1;
      check("arst mode", 32'(a_mode), 0);
      check("arst seg_len", 32'(a_seg), 0);
      check("arst mode_change", 32'(a_mc), 0);
      check("arst errors", 32'({a_errt, a_errc}), 0);
      check("arst checks_done", 32'(a_chk), 0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Saturation: CNT_W=2, five passing minimal rounds.
      for (int r = 1; r <= 5; r++) begin
         step(1, 1, 1, 0);
         step(1, 0, 0, 1);
         step(1, 1, 1, 0);
         step(1, 0, 0, 1);
         step(1, 0, 0, 0);
         check($sformatf("sat round%0d mode", r), 32'(a_mode), 0);
         check($sformatf("sat round%0d checks_done", r), 32'(a_chk), (r > 3) ? 3 : r);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
